uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART Tx controller/datapath among NUM_REQ byte-producing clients.
- Picks one requester per frame, round-robin, and latches its byte into a hold register.
- Presents the byte to the Tx via the tx_on / data_seen handshake, keeping the Tx back-to-back busy when traffic is pending.
- Sits between client logic (CSR writer, debug streamer, etc.) and the Tx controller FSM.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- DATA_SIZE, 8, frame data width; matches the Tx controller's data_size.
- ID_W, 2, width of the client index; must equal clog2(NUM_REQ).
- PREFIX_TAG, 4'hA, upper nibble of the header byte (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-client request; level, held until the matching ack.
- req_data  in  NUM_REQ*DATA_SIZE  client bytes, concatenated; client i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- ack  out  NUM_REQ  one-cycle pulse: the byte has been taken; client may drop req or change data.
- tx_on  out  1  to Tx: a frame is pending.
- tx_data  out  DATA_SIZE  to Tx: frame byte; stable from tx_on rise until tx_data_seen falls.
- tx_data_seen  in  1  from Tx: high for the whole start-bit period while the Tx samples tx_data.
- tx_busy  in  1  from Tx: a frame is in progress; status only.
- grant_valid  out  1  high while a latched frame is being delivered.
- grant_id  out  ID_W  client whose frame is held.

Behaviour:
- Reset (rst_n low, async): state=IDLE, rr_ptr=0, hold_reg=0, ack=0, tx_on=0, tx_data=0, grant_valid=0, grant_id=0.
- The FSM state and all outputs are registered.
- IDLE:
  - if req != 0, select the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - next cycle: hold_reg <= that client's byte, grant_id <= index, ack[index] pulses 1 cycle, grant_valid=1, go to PRESENT.
- PRESENT:
  - tx_on=1, tx_data=hold_reg.
  - on tx_data_seen=1, go to HOLD and drop tx_on.
- HOLD:
  - tx_data held at hold_reg.
  - on tx_data_seen falling, set rr_ptr = grant_id+1 (wraps NUM_REQ-1 -> 0), clear grant_valid, go to IDLE.
- Latency: req rise to ack is 2 cycles with the arbiter in IDLE; ack to tx_on is 1 cycle.
- Back-to-back: after HOLD the arbiter re-arbitrates while the Tx is still in data/parity/stop.
  - tx_on is already high when the Tx samples it at stop end, so there are no idle frames between pending bytes.
- Fairness: a client that keeps req high is not re-granted while another client is requesting.
- Simultaneous events:
  - req changes during PRESENT/HOLD are ignored.
  - a req arriving in the same cycle as the HOLD exit is seen in the following IDLE cycle.
- tx_busy is not used for sequencing. If tx_data_seen is already high on entry to PRESENT (a stale pulse), wait for it to fall first, then for a fresh rise.
- A client dropping req without an ack is legal; it is simply not selected.
- Reset mid-frame discards hold_reg; the client that was already acked does not resend.

Optional Feature:
- Macro: UART_ARB_ID_PREFIX_EN.
- Defined:
  - when the granted client differs from the last transmitted client (or on the first grant after reset), first deliver a header frame {PREFIX_TAG, zero-pad, grant_id} through PRESENT/HOLD, then the data byte.
  - adds state HDR; ack timing is unchanged (pulses at latch).
  - last_id register resets to "none".
- Undefined: no header frames and no HDR state; last_id is absent.

Decomposition:
- Shared package uart_pkg:
  - state enum IDLE/PRESENT/HOLD/HDR;
  - DATA_SIZE default; PREFIX_TAG;
  - a clog2 function.
- One sub-module: rr_picker, combinational. Inputs req and rr_ptr; outputs found and grant index. Rotate-priority search.

Test Plan:
- Single request: req=4'b0100, data2=8'h55. Expect ack[2] 2 cycles later, tx_on=1 the next cycle, tx_data=8'h55 held through tx_data_seen high, grant_id=2.
- All four requesting with data 8'h10..8'h13, Tx model looping. Expect tx_data order 10,11,12,13 and tx_on already high before each stop-bit end.
- Client 1 holds req continuously, client 3 requests once. Expect grant order 1,3,1,1.
- rst_n low while in HOLD. Expect tx_on=0, ack=0, grant_valid=0 immediately (async). After release, a new req=4'b0001 is granted with rr_ptr=0.
- Stale tx_data_seen high on entry to PRESENT for 5 cycles. Expect the arbiter to stay in PRESENT until tx_data_seen falls and then rises again.
- With UART_ARB_ID_PREFIX_EN:
  - client 2 sends 8'h7E twice: expect frames A2,7E,7E;
  - then client 0 sends 8'h01: expect A0,01.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART Tx arbiter slice: FSM states, debug
// view, data width / header tag defaults, and a constant clog2 helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2,
        HDR     = 2'd3
    } state_t;

    typedef struct packed {
        state_t state;
        logic   armed;
        logic   hdr_phase;
        logic   tx_busy;
    } arb_dbg_t;

    localparam int         UART_DATA_SIZE  = 8;
    localparam logic [3:0] UART_PREFIX_TAG = 4'hA;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Rotating-priority search: first set req bit at or after rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    grant
);

    logic [ID_W-1:0] idx;

    // Scan from farthest to nearest so the nearest hit overwrites earlier ones.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Tx among NUM_REQ byte clients.
// Optional header frame per client switch when UART_ARB_ID_PREFIX_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = UART_DATA_SIZE,
    parameter int ID_W      = clog2(NUM_REQ)
`ifdef UART_ARB_ID_PREFIX_EN
    ,
    parameter logic [3:0] PREFIX_TAG = UART_PREFIX_TAG
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           tx_on,
    output logic [DATA_SIZE-1:0]           tx_data,
    input  logic                           tx_data_seen,
    input  logic                           tx_busy,
    output logic                           grant_valid,
    output logic [ID_W-1:0]                grant_id,
    output arb_dbg_t                       dbg
);

    // Handshake: tx_on high means tx_data holds a frame byte; the Tx answers by
    // raising tx_data_seen for its start bit, and the byte stays stable until
    // tx_data_seen falls. A seen-high level is only accepted once it has been
    // observed low during PRESENT (armed), so stale pulses are ignored.

    state_t               state, next_state;
    logic [NUM_REQ-1:0]   req_q;
    logic [ID_W-1:0]      rr_ptr;
    logic [DATA_SIZE-1:0] hold_reg;
    logic                 armed;
    logic                 found;
    logic [ID_W-1:0]      pick_id;
    logic [DATA_SIZE-1:0] pick_data;
    logic                 need_hdr;
    logic                 hdr_phase;
    logic [ID_W-1:0]      rr_next;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
        .req    (req_q),
        .rr_ptr (rr_ptr),
        .found  (found),
        .grant  (pick_id)
    );

    assign pick_data = req_data[int'(pick_id)*DATA_SIZE +: DATA_SIZE];
    assign rr_next   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_ID_PREFIX_EN
    logic            last_valid;
    logic [ID_W-1:0] last_id;

    assign need_hdr = !last_valid || (last_id != pick_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid <= 1'b0;
            last_id    <= '0;
            hdr_phase  <= 1'b0;
        end else begin
            if (state == HDR) begin
                hdr_phase <= 1'b1;
            end else if (state == HOLD && !tx_data_seen) begin
                hdr_phase <= 1'b0;
                if (!hdr_phase) begin
                    last_valid <= 1'b1;
                    last_id    <= grant_id;
                end
            end
        end
    end
`else
    assign need_hdr  = 1'b0;
    assign hdr_phase = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = need_hdr ? HDR : PRESENT;
            HDR:     next_state = PRESENT;
            PRESENT: if (armed && tx_data_seen) next_state = HOLD;
            HOLD:    if (!tx_data_seen) next_state = hdr_phase ? PRESENT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            rr_ptr      <= '0;
            hold_reg    <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            ack         <= '0;
            tx_on       <= 1'b0;
            tx_data     <= '0;
            armed       <= 1'b0;
        end else begin
            req_q <= req;
            ack   <= '0;
            tx_on <= (state == PRESENT) && (next_state == PRESENT);
            armed <= (state == PRESENT) && (armed || !tx_data_seen);
            case (state)
                IDLE: begin
                    if (found) begin
                        hold_reg      <= pick_data;
                        tx_data       <= pick_data;
                        grant_id      <= pick_id;
                        grant_valid   <= 1'b1;
                        ack[pick_id]  <= 1'b1;
                    end
                end
`ifdef UART_ARB_ID_PREFIX_EN
                HDR: tx_data <= {PREFIX_TAG, {(DATA_SIZE-4-ID_W){1'b0}}, grant_id};
`endif
                HOLD: begin
                    if (!tx_data_seen) begin
                        if (hdr_phase) begin
                            tx_data <= hold_reg;
                        end else begin
                            rr_ptr      <= rr_next;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg = '{state: state, armed: armed, hdr_phase: hdr_phase, tx_busy: tx_busy};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, round-robin order, fairness,
// async reset mid-frame, stale tx_data_seen, and (optionally) header frames.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_on;
    logic [7:0]  tx_data;
    logic        tx_data_seen;
    logic        tx_busy;
    logic        grant_valid;
    logic [1:0]  grant_id;
    arb_dbg_t    dbg;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int left[4];
    logic [7:0] exp_q[$];

    uart_tx_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .tx_on        (tx_on),
        .tx_data      (tx_data),
        .tx_data_seen (tx_data_seen),
        .tx_busy      (tx_busy),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .dbg          (dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle; client models drop req once their grant budget is used up.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (ack[i] === 1'b1) begin
                ack_cnt++;
                if (left[i] > 0) left[i]--;
                if (left[i] == 0) req[i] = 1'b0;
            end
        end
    endtask

    task automatic client_req(input int id, input logic [7:0] b, input int n);
        req_data[id*8 +: 8] = b;
        left[id] = n;
        req[id]  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Tx controller model: start bit drives tx_data_seen, then data/parity/stop.
    task automatic tx_frame(input string tag, input bit more);
        int n;
        logic [7:0] e;
        n = 0;
        while (tx_on !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({tag, " on"}, 32'(tx_on), 32'd1);
        tx_data_seen = 1'b1;
        tx_busy      = 1'b1;
        repeat (4) step();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, " data"}, 32'(tx_data), 32'(e));
        check({tag, " on_drop"}, 32'(tx_on), 32'd0);
        tx_data_seen = 1'b0;
        repeat (10) step();
        if (more) check({tag, " b2b"}, 32'(tx_on), 32'd1);
        tx_busy = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int target);
        int n;
        n = 0;
        while (ack_cnt < target && n < 50) begin
            step();
            n++;
        end
        check({tag, " ack_seen"}, 32'(ack_cnt >= target), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        req          = '0;
        req_data     = '0;
        tx_data_seen = 1'b0;
        tx_busy      = 1'b0;
        for (int i = 0; i < 4; i++) left[i] = 0;

        // reset state
        do_reset();
        check("rst tx_on", 32'(tx_on), 32'd0);
        check("rst ack", 32'(ack), 32'd0);
        check("rst grant_valid", 32'(grant_valid), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst state", 32'(dbg.state), 32'(IDLE));

        // single request, cycle-exact
        client_req(2, 8'h55, 1);
        step();
        check("t1 ack early", 32'(ack), 32'd0);
        step();
        check("t1 ack", 32'(ack), 32'h4);
        check("t1 grant_id", 32'(grant_id), 32'd2);
        check("t1 grant_valid", 32'(grant_valid), 32'd1);
        check("t1 tx_on early", 32'(tx_on), 32'd0);
        step();
        check("t1 tx_on", 32'(tx_on), 32'd1);
        check("t1 tx_data", 32'(tx_data), 32'h55);
        check("t1 ack pulse", 32'(ack), 32'd0);
        tx_data_seen = 1'b1;
        step();
        check("t1 state hold", 32'(dbg.state), 32'(HOLD));
        check("t1 tx_on drop", 32'(tx_on), 32'd0);
        repeat (2) step();
        check("t1 tx_data held", 32'(tx_data), 32'h55);
        tx_data_seen = 1'b0;
        step();
        check("t1 state idle", 32'(dbg.state), 32'(IDLE));
        check("t1 grant_valid clr", 32'(grant_valid), 32'd0);

        // all four requesting, round-robin from rr_ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            client_req(i, 8'h10 + 8'(i), 1);
            exp_q.push_back(8'h10 + 8'(i));
        end
        tx_frame("rr0", 1'b1);
        tx_frame("rr1", 1'b1);
        tx_frame("rr2", 1'b1);
        tx_frame("rr3", 1'b0);

        // fairness: client 1 persistent, client 3 once -> 1,3,1,1
        client_req(1, 8'h21, 3);
        client_req(3, 8'h23, 1);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h21);
        tx_frame("fair0", 1'b1);
        tx_frame("fair1", 1'b1);
        tx_frame("fair2", 1'b1);
        tx_frame("fair3", 1'b0);
        check("fair req dropped", 32'(req), 32'd0);

        // async reset while in HOLD
        client_req(2, 8'h66, 1);
        begin
            int n;
            n = 0;
            while (tx_on !== 1'b1 && n < 50) begin
                step();
                n++;
            end
        end
        tx_data_seen = 1'b1;
        step();
        check("rh state hold", 32'(dbg.state), 32'(HOLD));
        check("rh grant_valid pre", 32'(grant_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rh tx_on", 32'(tx_on), 32'd0);
        check("rh ack", 32'(ack), 32'd0);
        check("rh grant_valid", 32'(grant_valid), 32'd0);
        check("rh tx_data", 32'(tx_data), 32'd0);
        check("rh state", 32'(dbg.state), 32'(IDLE));
        tx_data_seen = 1'b0;
        tx_busy      = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        client_req(0, 8'h01, 1);
        client_req(3, 8'h03, 1);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h03);
        tx_frame("rh0", 1'b1);
        tx_frame("rh1", 1'b0);

        // stale tx_data_seen high on entry to PRESENT
        tx_data_seen = 1'b1;
        client_req(1, 8'h5A, 1);
        wait_ack("st", ack_cnt + 1);
        repeat (5) step();
        check("st state present", 32'(dbg.state), 32'(PRESENT));
        check("st tx_on", 32'(tx_on), 32'd1);
        tx_data_seen = 1'b0;
        step();
        check("st still present", 32'(dbg.state), 32'(PRESENT));
        tx_data_seen = 1'b1;
        step();
        check("st state hold", 32'(dbg.state), 32'(HOLD));
        check("st tx_data", 32'(tx_data), 32'h5A);
        check("st tx_on drop", 32'(tx_on), 32'd0);
        tx_data_seen = 1'b0;
        step();
        check("st state idle", 32'(dbg.state), 32'(IDLE));
        check("st grant_valid", 32'(grant_valid), 32'd0);

        // header frames on client switch (plain data bytes when disabled)
        client_req(2, 8'h7E, 2);
`ifdef UART_ARB_ID_PREFIX_EN
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h7E);
        tx_frame("px_h2", 1'b1);
        tx_frame("px_d2a", 1'b1);
        tx_frame("px_d2b", 1'b0);
        client_req(0, 8'h01, 1);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h01);
        tx_frame("px_h0", 1'b1);
        tx_frame("px_d0", 1'b0);
`else
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'h7E);
        tx_frame("px_d2a", 1'b1);
        tx_frame("px_d2b", 1'b0);
        client_req(0, 8'h01, 1);
        exp_q.push_back(8'h01);
        tx_frame("px_d0", 1'b0);
`endif

        // final report
        check("exp_q drained", 32'(exp_q.size()), 32'd0);
        check("final idle", 32'(dbg.state), 32'(IDLE));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
